forest_bg_fetch: RTL and testbench

- Upstream feeder of the colour mapper. Turns the VGA scan position (DrawX, DrawY) into a 4-bit forest-background palette index.
- Applies 2x upscaling and a horizontal scroll offset, then reads a synchronous background index ROM.
- Outputs the index together with pipeline-aligned DrawX/DrawY, so the ball/sprite logic and the colour mapper see a matched pixel.
- Scroll changes are handshaked and take effect only at frame boundaries, so no frame tears.

---
 rtl/forest_pkg.sv | 33 +++
 rtl/forest_bg_fetch_if.sv | 32 +++
 rtl/bg_addr_gen.sv | 71 +++++++
 rtl/forest_bg_fetch.sv | 116 +++++++++++
 tb/tb_forest_bg_fetch.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/forest_pkg.sv
// Shared constants, types and the scroll wrap helper for the forest background fetcher.
// Geometry is fixed at 320x240 source, upscaled 2x onto a 640x480 visible screen.
package forest_pkg;

  localparam int SRC_W       = 320;
  localparam int SRC_H       = 240;
  localparam int SCALE_SHIFT = 1;
  localparam int VIS_W       = 640;
  localparam int VIS_H       = 480;
  localparam int ADDR_W      = $clog2(SRC_W * SRC_H);

  localparam logic signed [9:0] SRC_W_S = 10'(SRC_W);

  typedef logic [3:0] idx_t;

  typedef enum logic {
    IDLE,
    PEND
  } scroll_st_t;

  // Signed 10-bit add so a negative delta can fold back from the left edge.
  function automatic logic [8:0] scroll_wrap(input logic [8:0] cur, input logic signed [7:0] dx);
    logic signed [9:0] sum;
    sum = $signed({1'b0, cur}) + $signed({{2{dx[7]}}, dx});
    if (sum < 0) begin
      sum = sum + SRC_W_S;
    end else if (sum >= SRC_W_S) begin
      sum = sum - SRC_W_S;
    end
    return sum[8:0];
  endfunction

endpackage

// File: rtl/forest_bg_fetch_if.sv
// Scan, scroll-handshake, ROM and pixel-output signals of the background fetcher.
// master drives scan/scroll/ROM data; slave is the fetcher itself.
interface forest_bg_fetch_if;
  import forest_pkg::*;

  logic                    pix_en;
  logic [9:0]              DrawX;
  logic [9:0]              DrawY;
  logic                    frame_start;
  logic                    scroll_req;
  logic signed [7:0]       scroll_dx;
  logic                    scroll_ack;
  logic                    busy;
  logic [8:0]              scroll_x;
  logic [ADDR_W-1:0]       rom_addr;
  idx_t                    rom_data;
  idx_t                    idx_forest;
  logic [9:0]              DrawX_d;
  logic [9:0]              DrawY_d;
  logic                    pix_valid;

  modport master (
    output pix_en, DrawX, DrawY, frame_start, scroll_req, scroll_dx, rom_data,
    input  scroll_ack, busy, scroll_x, rom_addr, idx_forest, DrawX_d, DrawY_d, pix_valid
  );

  modport slave (
    input  pix_en, DrawX, DrawY, frame_start, scroll_req, scroll_dx, rom_data,
    output scroll_ack, busy, scroll_x, rom_addr, idx_forest, DrawX_d, DrawY_d, pix_valid
  );

endinterface

// File: rtl/bg_addr_gen.sv
// S0/S1 of the fetch pipeline: downscale, scroll-wrap, then row*320+col ROM address.
// Two pix_en ticks from scan position to rom_addr; all registers hold while en=0.
module bg_addr_gen
  import forest_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [8:0]        scroll_x,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              vis,
  output logic [9:0]        x_s1,
  output logic [9:0]        y_s1
);

  logic [9:0] sx;
  logic [9:0] sy;
  logic [9:0] tx_sum;
  logic [9:0] tx;
  logic       vis_c;

  logic [9:0] tx_s0;
  logic [9:0] sy_s0;
  logic       vis_s0;
  logic [9:0] x_s0;
  logic [9:0] y_s0;

  logic [ADDR_W-1:0] sy_a;
  logic [ADDR_W-1:0] addr_c;

  // Both operands are below SRC_W for visible pixels, so one subtract wraps.
  always_comb begin
    sx     = draw_x >> SCALE_SHIFT;
    sy     = draw_y >> SCALE_SHIFT;
    tx_sum = sx + {1'b0, scroll_x};
    tx     = (tx_sum >= 10'(SRC_W)) ? (tx_sum - 10'(SRC_W)) : tx_sum;
    vis_c  = (draw_x < 10'(VIS_W)) && (draw_y < 10'(VIS_H));
  end

  always_comb begin
    sy_a   = ADDR_W'(sy_s0);
    addr_c = (sy_a << 8) + (sy_a << 6) + ADDR_W'(tx_s0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_s0    <= '0;
      sy_s0    <= '0;
      vis_s0   <= 1'b0;
      x_s0     <= '0;
      y_s0     <= '0;
      rom_addr <= '0;
      vis      <= 1'b0;
      x_s1     <= '0;
      y_s1     <= '0;
    end else if (en) begin
      tx_s0    <= tx;
      sy_s0    <= sy;
      vis_s0   <= vis_c;
      x_s0     <= draw_x;
      y_s0     <= draw_y;
      rom_addr <= addr_c;
      vis      <= vis_s0;
      x_s1     <= x_s0;
      y_s1     <= y_s0;
    end
  end

endmodule

// File: rtl/forest_bg_fetch.sv
// Forest background fetcher: scan position -> 4-bit palette index, 3 pix_en ticks latency.
// Pipeline stalls on pix_en=0; scroll requests wait (busy) until frame_start, then ack.
module forest_bg_fetch
  import forest_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  forest_bg_fetch_if.slave   bus
);

  scroll_st_t        state;
  scroll_st_t        state_nxt;
  logic signed [7:0] pend_dx;
  logic signed [7:0] pend_dx_nxt;
  logic [8:0]        scroll_r;
  logic [8:0]        scroll_nxt;
  logic              ack_r;
  logic              ack_nxt;

  logic [ADDR_W-1:0] rom_addr;
  logic              vis_s1;
  logic [9:0]        x_s1;
  logic [9:0]        y_s1;

  idx_t              idx_r;
  logic [9:0]        x_d;
  logic [9:0]        y_d;
  logic [1:0]        vld_pipe;
  logic              pix_valid_r;

  bg_addr_gen u_addr (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .en       (bus.pix_en),
    .draw_x   (bus.DrawX),
    .draw_y   (bus.DrawY),
    .scroll_x (scroll_r),
    .rom_addr (rom_addr),
    .vis      (vis_s1),
    .x_s1     (x_s1),
    .y_s1     (y_s1)
  );

  // A request arriving with frame_start in PEND still wins over the latched delta.
  always_comb begin
    state_nxt   = state;
    pend_dx_nxt = pend_dx;
    scroll_nxt  = scroll_r;
    ack_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.scroll_req) begin
          pend_dx_nxt = bus.scroll_dx;
          if (bus.frame_start) begin
            scroll_nxt = scroll_wrap(scroll_r, bus.scroll_dx);
            ack_nxt    = 1'b1;
          end else begin
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (bus.scroll_req) begin
          pend_dx_nxt = bus.scroll_dx;
        end
        if (bus.frame_start) begin
          scroll_nxt = scroll_wrap(scroll_r, pend_dx_nxt);
          ack_nxt    = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pend_dx  <= '0;
      scroll_r <= '0;
      ack_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_dx  <= pend_dx_nxt;
      scroll_r <= scroll_nxt;
      ack_r    <= ack_nxt;
    end
  end

  // S2: rom_data answers the address issued on the previous tick.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      idx_r       <= '0;
      x_d         <= '0;
      y_d         <= '0;
      vld_pipe    <= '0;
      pix_valid_r <= 1'b0;
    end else if (bus.pix_en) begin
      idx_r       <= vis_s1 ? bus.rom_data : idx_t'(0);
      x_d         <= x_s1;
      y_d         <= y_s1;
      vld_pipe    <= {vld_pipe[0], 1'b1};
      pix_valid_r <= vld_pipe[1];
    end
  end

  assign bus.scroll_ack = ack_r;
  assign bus.busy       = (state == PEND);
  assign bus.scroll_x   = scroll_r;
  assign bus.rom_addr   = rom_addr;
  assign bus.idx_forest = idx_r;
  assign bus.DrawX_d    = x_d;
  assign bus.DrawY_d    = y_d;
  assign bus.pix_valid  = pix_valid_r;

endmodule

// File: tb/tb_forest_bg_fetch.sv
// Scoreboard bench for forest_bg_fetch: pixel and scroll-ack expectations are queued at issue
// time and checked by a negedge monitor whenever the DUT presents a pixel or an ack.
module tb_forest_bg_fetch;

  logic Clk;
  logic Reset_n;

  forest_bg_fetch_if bus ();

  forest_bg_fetch dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int idx;
    int x;
    int y;
  } px_t;

  px_t pixq[$];
  int  ackq[$];
  int  total = 0;
  int  bad   = 0;
  int  exp_sc = 0;
  px_t last_exp;
  bit  have_last = 0;
  bit  pe_q = 0;
  bit  rst_q = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_val(input int a);
    return 4'((a * 5) ^ (a >> 4) ^ (a >> 9));
  endfunction

  // Synchronous ROM: data for an address appears one Clk later.
  always @(posedge Clk) bus.rom_data <= rom_val(int'(bus.rom_addr));

  always @(posedge Clk) begin
    pe_q  <= bus.pix_en;
    rst_q <= Reset_n;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_px(input string nm, input px_t e);
    total++;
    if (int'(bus.idx_forest) != e.idx || int'(bus.DrawX_d) != e.x || int'(bus.DrawY_d) != e.y) begin
      bad++;
      $display("FAIL %s: got idx=%0d x=%0d y=%0d expected idx=%0d x=%0d y=%0d",
               nm, bus.idx_forest, bus.DrawX_d, bus.DrawY_d, e.idx, e.x, e.y);
    end
  endtask

  // Monitor: pops on output ticks, checks hold on stalled cycles, pops on every ack.
  always @(negedge Clk) begin
    px_t e;
    int  es;
    if (rst_q && bus.pix_valid === 1'b1) begin
      if (pe_q) begin
        if (pixq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pix_underflow: got unexpected pixel x=%0d y=%0d", bus.DrawX_d, bus.DrawY_d);
        end else begin
          e = pixq.pop_front();
          last_exp  = e;
          have_last = 1'b1;
          cmp_px("pix", e);
        end
      end else if (have_last) begin
        cmp_px("hold", last_exp);
      end
    end
    if (bus.scroll_ack === 1'b1) begin
      if (ackq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ack: got ack with scroll_x=%0d expected no ack", bus.scroll_x);
      end else begin
        es = ackq.pop_front();
        chk("ack_scroll_x", int'(bus.scroll_x), es);
      end
    end
  end

  task automatic drive(input bit pe, input int x, input int y, input bit fs, input bit rq, input int dx);
    @(negedge Clk);
    bus.pix_en      = pe;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.frame_start = fs;
    bus.scroll_req  = rq;
    bus.scroll_dx   = 8'(dx);
  endtask

  task automatic idle(input bit fs, input bit rq, input int dx);
    drive(1'b0, 0, 0, fs, rq, dx);
  endtask

  // Ticks are spaced at least two Clk apart so the one-cycle ROM latency is covered.
  task automatic px(input int x, input int y, input int gap);
    px_t e;
    int  addr;
    addr  = (y / 2) * 320 + ((x / 2) + exp_sc) % 320;
    e.x   = x;
    e.y   = y;
    e.idx = (x < 640 && y < 480) ? int'(rom_val(addr)) : 0;
    pixq.push_back(e);
    drive(1'b1, x, y, 1'b0, 1'b0, 0);
    repeat (gap) drive(1'b0, x, y, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    Reset_n         = 1'b0;
    bus.pix_en      = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.frame_start = 1'b0;
    bus.scroll_req  = 1'b0;
    bus.scroll_dx   = '0;

    repeat (3) idle(0, 0, 0);
    chk("rst_idx", int'(bus.idx_forest), 0);
    chk("rst_xd", int'(bus.DrawX_d), 0);
    chk("rst_yd", int'(bus.DrawY_d), 0);
    chk("rst_valid", int'(bus.pix_valid), 0);
    chk("rst_addr", int'(bus.rom_addr), 0);
    chk("rst_scroll", int'(bus.scroll_x), 0);
    chk("rst_ack", int'(bus.scroll_ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    Reset_n = 1'b1;

    // Basic mapping, visibility boundaries, last source address.
    exp_sc = 0;
    px(10, 4, 1);
    chk("valid_tick1", int'(bus.pix_valid), 0);
    px(700, 100, 1);
    chk("addr_645", int'(bus.rom_addr), 645);
    chk("valid_tick2", int'(bus.pix_valid), 0);
    px(10, 480, 1);
    chk("valid_tick3", int'(bus.pix_valid), 1);
    px(639, 479, 1);
    px(0, 0, 1);
    chk("addr_max", int'(bus.rom_addr), 76799);
    px(640, 0, 1);
    px(639, 0, 1);
    px(0, 479, 1);

    // Request and frame_start together in IDLE: 0 - 20 wraps to 300.
    ackq.push_back(300);
    idle(1, 1, -20);
    idle(0, 0, 0);
    chk("same_busy", int'(bus.busy), 0);
    chk("same_scroll", int'(bus.scroll_x), 300);
    chk("same_ack", int'(bus.scroll_ack), 1);
    idle(0, 0, 0);
    chk("same_ack_drop", int'(bus.scroll_ack), 0);

    // Pending request applied five cycles later: 300 + 30 wraps to 10.
    ackq.push_back(10);
    idle(0, 1, 30);
    for (int i = 0; i < 4; i++) begin
      idle(0, 0, 0);
      chk("pend_busy", int'(bus.busy), 1);
      chk("pend_scroll", int'(bus.scroll_x), 300);
    end
    idle(1, 0, 0);
    chk("pend_busy_fs", int'(bus.busy), 1);
    idle(0, 0, 0);
    chk("apply_busy", int'(bus.busy), 0);
    chk("apply_scroll", int'(bus.scroll_x), 10);
    idle(0, 0, 0);
    chk("apply_ack_drop", int'(bus.scroll_ack), 0);
    exp_sc = 10;
    px(0, 0, 1);
    px(638, 2, 1);
    chk("addr_10", int'(bus.rom_addr), 10);
    px(2, 2, 1);

    // 10 - 5 = 5, then 5 - 20 wraps to 305.
    ackq.push_back(5);
    idle(1, 1, -5);
    idle(0, 0, 0);
    chk("s5_scroll", int'(bus.scroll_x), 5);
    ackq.push_back(305);
    idle(1, 1, -20);
    idle(0, 0, 0);
    chk("s305_busy", int'(bus.busy), 0);
    chk("s305_ack", int'(bus.scroll_ack), 1);
    chk("s305_scroll", int'(bus.scroll_x), 305);
    idle(0, 0, 0);
    chk("s305_ack_drop", int'(bus.scroll_ack), 0);
    exp_sc = 305;
    px(40, 0, 1);
    px(638, 10, 1);
    px(100, 300, 1);

    // Last write wins: +3 then +7 pending, 305 + 7 = 312, single ack.
    ackq.push_back(312);
    idle(0, 1, 3);
    idle(0, 0, 0);
    idle(0, 0, 0);
    chk("lw_busy1", int'(bus.busy), 1);
    idle(0, 1, 7);
    idle(0, 0, 0);
    chk("lw_busy2", int'(bus.busy), 1);
    idle(1, 0, 0);
    idle(0, 0, 0);
    chk("lw_scroll", int'(bus.scroll_x), 312);
    chk("lw_busy_clr", int'(bus.busy), 0);
    idle(0, 0, 0);
    idle(0, 0, 0);

    // Extreme deltas: 312 + 127 -> 119, 119 - 128 -> 311.
    ackq.push_back(119);
    idle(1, 1, 127);
    idle(0, 0, 0);
    chk("wrap_pos", int'(bus.scroll_x), 119);
    ackq.push_back(311);
    idle(1, 1, -128);
    idle(0, 0, 0);
    chk("wrap_neg", int'(bus.scroll_x), 311);
    idle(0, 0, 0);
    exp_sc = 311;
    px(20, 20, 3);
    px(30, 6, 2);
    px(638, 478, 3);
    px(0, 0, 1);

    // Reset while a request is pending discards it and the pipeline.
    idle(0, 1, 50);
    idle(0, 0, 0);
    chk("pre_rst_busy", int'(bus.busy), 1);
    Reset_n = 1'b0;
    pixq.delete();
    idle(0, 0, 0);
    chk("mid_rst_scroll", int'(bus.scroll_x), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_valid", int'(bus.pix_valid), 0);
    idle(0, 0, 0);
    Reset_n = 1'b1;
    idle(1, 0, 0);
    idle(0, 0, 0);
    idle(1, 0, 0);
    idle(0, 0, 0);
    chk("post_rst_scroll", int'(bus.scroll_x), 0);
    chk("post_rst_busy", int'(bus.busy), 0);
    exp_sc = 0;
    px(6, 8, 1);
    chk("post_valid1", int'(bus.pix_valid), 0);
    px(8, 6, 1);
    chk("post_valid2", int'(bus.pix_valid), 0);
    px(100, 200, 1);
    chk("post_valid3", int'(bus.pix_valid), 1);
    px(1, 1, 2);

    chk("pix_inflight", pixq.size(), 2);
    chk("ack_leftover", ackq.size(), 0);
    repeat (3) idle(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
